// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with flush/hold/bubble/load modes and
// saturating bubble/flush event counters for CP0 performance debug.
module pipe_stage_reg #(
   parameter int                 DATA_W    = 128,
   parameter logic [DATA_W-1:0]  KEEP_MASK = {DATA_W{1'b0}},
   parameter int                 CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              hold,
   input  logic              bubble,
   input  logic              d_valid,
   input  logic [DATA_W-1:0] d_data,
   input  logic              cnt_clr,
   output logic              q_valid,
   output logic              q_bubble,
   output logic [DATA_W-1:0] q_data,
   output logic [CNT_W-1:0]  bubble_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              bub_q, bub_d;
   logic [CNT_W-1:0]  bcnt_q, bcnt_d;
   logic [CNT_W-1:0]  fcnt_q, fcnt_d;
   logic              do_flush, do_bubble;

   // hold masks bubble, flush masks everything
   assign do_flush  = flush;
   assign do_bubble = !flush && !hold && bubble;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      bub_d   = bub_q;
      if (flush) begin
         data_d  = '0;
         valid_d = 1'b0;
         bub_d   = 1'b0;
      end else if (hold) begin
         data_d  = data_q;
      end else if (bubble) begin
         data_d  = d_data & KEEP_MASK;
         valid_d = 1'b0;
         bub_d   = 1'b1;
      end else begin
         data_d  = d_data;
         valid_d = d_valid;
         bub_d   = 1'b0;
      end
   end

   always_comb begin
      bcnt_d = bcnt_q;
      fcnt_d = fcnt_q;
      if (cnt_clr) begin
         bcnt_d = '0;
         fcnt_d = '0;
      end else begin
         if (do_bubble && bcnt_q != CNT_MAX) bcnt_d = bcnt_q + 1'b1;
         if (do_flush  && fcnt_q != CNT_MAX) fcnt_d = fcnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         bub_q   <= 1'b0;
         bcnt_q  <= '0;
         fcnt_q  <= '0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         bub_q   <= bub_d;
         bcnt_q  <= bcnt_d;
         fcnt_q  <= fcnt_d;
      end
   end

   assign q_data     = data_q;
   assign q_valid    = valid_q;
   assign q_bubble   = bub_q;
   assign bubble_cnt = bcnt_q;
   assign flush_cnt  = fcnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: spec-level model checked every cycle plus
// directed vectors with hand-computed expectations.
module tb_pipe_stage_reg;

   localparam int          DW   = 64;
   localparam logic [63:0] KM   = 64'h0000_0000_FFFF_FFFF;
   localparam int          CW   = 2;
   localparam int          MAXC = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst, flush, hold, bubble, d_valid, cnt_clr;
   logic [DW-1:0] d_data;
   logic          q_valid, q_bubble;
   logic [DW-1:0] q_data;
   logic [CW-1:0] bubble_cnt, flush_cnt;

   int checks   = 0;
   int failures = 0;

   pipe_stage_reg #(.DATA_W(DW), .KEEP_MASK(KM), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .flush(flush), .hold(hold), .bubble(bubble),
      .d_valid(d_valid), .d_data(d_data), .cnt_clr(cnt_clr),
      .q_valid(q_valid), .q_bubble(q_bubble), .q_data(q_data),
      .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   // model: what the stage must contain after each edge
   logic [DW-1:0] m_data;
   logic          m_valid, m_bub, m_ok = 1'b0;
   int            m_bc, m_fc;

   always @(posedge clk) begin
      if (!rst) begin
         m_data = '0; m_valid = 0; m_bub = 0; m_bc = 0; m_fc = 0; m_ok = 1'b1;
      end else begin
         if (flush) begin
            m_data = '0; m_valid = 0; m_bub = 0;
            m_fc = (m_fc < MAXC) ? m_fc + 1 : MAXC;
         end else if (!hold) begin
            if (bubble) begin
               m_data = d_data & KM; m_valid = 0; m_bub = 1;
               m_bc = (m_bc < MAXC) ? m_bc + 1 : MAXC;
            end else begin
               m_data = d_data; m_valid = d_valid; m_bub = 0;
            end
         end
         if (cnt_clr) begin m_bc = 0; m_fc = 0; end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (m_ok) begin
         chk("model q_data",     q_data,           m_data);
         chk("model q_valid",    64'(q_valid),     64'(m_valid));
         chk("model q_bubble",   64'(q_bubble),    64'(m_bub));
         chk("model bubble_cnt", 64'(bubble_cnt),  64'(m_bc));
         chk("model flush_cnt",  64'(flush_cnt),   64'(m_fc));
      end
   end

   task automatic drv(input logic r, input logic f, input logic h, input logic b,
                      input logic v, input logic [DW-1:0] d, input logic c);
      rst = r; flush = f; hold = h; bubble = b; d_valid = v; d_data = d; cnt_clr = c;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   initial begin
      drv(0, 1, 0, 0, 1, '1, 1);
      tick(); tick();
      chk("reset q_data", q_data, 64'h0);
      chk("reset q_valid", 64'(q_valid), 64'h0);
      chk("reset q_bubble", 64'(q_bubble), 64'h0);
      chk("reset counters", {bubble_cnt, flush_cnt}, 64'h0);

      drv(1, 0, 0, 0, 1, 64'h0000_0000_DEAD_BEEF, 0);
      tick();
      chk("load data", q_data, 64'h0000_0000_DEAD_BEEF);
      chk("load valid", 64'(q_valid), 64'h1);
      d_data = 64'h0000_0000_1234_5678;
      #2;
      chk("latency pre-edge", q_data, 64'h0000_0000_DEAD_BEEF);
      tick();
      chk("latency post-edge", q_data, 64'h0000_0000_1234_5678);
      drv(1, 0, 0, 0, 0, 64'h0BAD, 0);
      tick();
      chk("load invalid", 64'(q_valid), 64'h0);

      drv(1, 0, 0, 1, 1, 64'hAAAA_AAAA_0000_3008, 0);
      tick();
      chk("bubble mask data", q_data, 64'h0000_0000_0000_3008);
      chk("bubble valid", 64'(q_valid), 64'h0);
      chk("bubble flag", 64'(q_bubble), 64'h1);
      chk("bubble cnt 1", 64'(bubble_cnt), 64'h1);

      drv(1, 1, 1, 1, 1, 64'hFFFF, 0);
      tick();
      chk("prio flush data", q_data, 64'h0);
      chk("prio flush cnt", 64'(flush_cnt), 64'h1);
      chk("prio bubble cnt", 64'(bubble_cnt), 64'h1);

      drv(1, 0, 0, 0, 1, 64'h1111_2222_3333_4444, 0);
      tick();
      drv(1, 0, 1, 1, 0, 64'h9999, 0);
      repeat (3) tick();
      chk("hold+bubble data", q_data, 64'h1111_2222_3333_4444);
      chk("hold+bubble valid", 64'(q_valid), 64'h1);
      chk("hold+bubble cnt", 64'(bubble_cnt), 64'h1);

      for (int i = 0; i < 5; i++) begin
         drv(1, 0, 0, 1, 1, 64'(i + 64'h100), 0);
         tick();
      end
      chk("bubble saturate", 64'(bubble_cnt), 64'h3);
      drv(1, 0, 0, 1, 1, 64'h0, 1);
      tick();
      chk("clr beats bubble", 64'(bubble_cnt), 64'h0);
      chk("clr keeps q_bubble", 64'(q_bubble), 64'h1);

      drv(1, 1, 0, 0, 0, 64'h0, 0);
      repeat (4) tick();
      chk("flush saturate", 64'(flush_cnt), 64'h3);
      drv(1, 1, 0, 0, 0, 64'h0, 1);
      tick();
      chk("clr beats flush", 64'(flush_cnt), 64'h0);

      drv(1, 0, 0, 1, 0, 64'h0, 0);
      tick();
      drv(1, 0, 0, 0, 1, 64'h55, 0);
      tick();
      drv(1, 0, 1, 0, 0, 64'hEE, 0);
      repeat (2) tick();
      chk("hold data 55", q_data, 64'h55);
      rst = 1'b0;
      tick();
      chk("mid-hold reset data", q_data, 64'h0);
      chk("mid-hold reset cnts", {bubble_cnt, flush_cnt}, 64'h0);
      drv(1, 0, 0, 0, 1, 64'h77, 0);
      tick();
      chk("resume load data", q_data, 64'h77);
      chk("resume load valid", 64'(q_valid), 64'h1);

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
